// File: rtl/spi_rxm_responder_pkg.sv
// Shared frame constants and FSM state encoding for the SPI register-file responder.
package spi_rxm_pkg;
    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;
endpackage

// File: rtl/spi_rxm_responder_if.sv
// SPI pin bundle between the spi_rxm master and the register-file responder.
interface spi_rxm_responder_if;
    logic spi_sclk;
    logic spi_ss_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sclk, spi_ss_n, spi_mosi,
        input  spi_miso, spi_miso_oe
    );

    modport slave (
        input  spi_sclk, spi_ss_n, spi_mosi,
        output spi_miso, spi_miso_oe
    );
endinterface

// File: rtl/spi_rxm_responder_sync_edge_det.sv
// N-stage synchronizer for an asynchronous pin with registered one-cycle rise/fall pulses.
module sync_edge_det #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{INIT}};
            r_prev <= INIT;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule

// File: rtl/spi_rxm_responder.sv
// SPI mode-0 slave register file: decodes 16-bit R/W frames, holds control registers,
// returns register contents on MISO. All SPI pins are oversampled in the clk domain.
module spi_rxm_responder
    import spi_rxm_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    spi_rxm_responder_if.slave       spi,
    output logic [(8<<ADDR_W)-1:0]   regs_flat,
    output logic                     wr_stb,
    output logic [ADDR_BITS-1:0]     wr_addr,
    output logic [7:0]               wr_data,
    output logic                     frame_err,
    output logic                     busy
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam int CNT_W    = $clog2(FRAME_BITS);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CMD  = CMD;
    localparam logic [1:0] S_DATA = DATA;
    localparam logic [1:0] S_DONE = DONE;

    function automatic logic addr_ok(input logic [ADDR_BITS-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;

    sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_det (
        .i_clk(clk), .i_rst_n(reset_n), .i_d(spi.spi_sclk),
        .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss_det (
        .i_clk(clk), .i_rst_n(reset_n), .i_d(spi.spi_ss_n),
        .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [6:0]             r_rx;
    logic                   r_rw;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [7:0]             r_tx;
    logic                   r_miso;
    logic                   r_oe;
    logic [7:0]             r_regs [NUM_REGS];
    logic                   r_wr_stb;
    logic [ADDR_BITS-1:0]   r_wr_addr;
    logic [7:0]             r_wr_data;
    logic                   r_frame_err;

    // MOSI gets only the plain synchronizer; it is one cycle ahead of the SCLK
    // rise pulse, which still lands well inside the stable half-period.
    logic       w_mosi;
    logic [7:0] w_shift_in;
    logic [7:0] w_rd_data;

    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_shift_in = {r_rx, w_mosi};
    assign w_rd_data  = addr_ok(w_shift_in[6:0]) ? r_regs[w_shift_in[ADDR_W-1:0]] : 8'h00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mosi_sync <= '0;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rx        <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_tx        <= '0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
            r_wr_stb    <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_ss_fall)      r_oe <= 1'b1;
            else if (w_ss_rise) r_oe <= 1'b0;

            // SS_n release outranks any SCLK event, including the 16th rise.
            if (w_ss_rise) begin
                if (r_state == S_CMD || r_state == S_DATA) r_frame_err <= 1'b1;
                r_state <= S_IDLE;
                r_miso  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_ss_fall) begin
                            r_state <= S_CMD;
                            r_cnt   <= '0;
                            r_miso  <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (w_sclk_rise) begin
                            r_rx  <= w_shift_in[6:0];
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == CNT_W'(CMD_BITS-1)) begin
                                r_state <= S_DATA;
                                r_rw    <= w_shift_in[7];
                                r_addr  <= w_shift_in[6:0];
                                r_tx    <= w_shift_in[7] ? w_rd_data : 8'h00;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_sclk_fall) begin
                            r_miso <= r_tx[7];
                            r_tx   <= r_tx << 1;
                        end
                        if (w_sclk_rise) begin
                            r_rx  <= w_shift_in[6:0];
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == CNT_W'(FRAME_BITS-1)) begin
                                r_state <= S_DONE;
                                if (!r_rw && addr_ok(r_addr)) begin
                                    r_regs[r_addr[ADDR_W-1:0]] <= w_shift_in;
                                    r_wr_stb  <= 1'b1;
                                    r_wr_addr <= r_addr;
                                    r_wr_data <= w_shift_in;
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        r_miso <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = r_regs[g];
    end

    assign spi.spi_miso    = r_miso;
    assign spi.spi_miso_oe = r_oe;
    assign wr_stb          = r_wr_stb;
    assign wr_addr         = r_wr_addr;
    assign wr_data         = r_wr_data;
    assign frame_err       = r_frame_err;
    assign busy            = (r_state != S_IDLE);
endmodule

// File: tb/tb_spi_rxm_responder.sv
// Directed bench for spi_rxm_responder: bit-banged SPI frames at several SCLK:clk ratios.
module tb_spi_rxm_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_rxm_responder_if bus ();

    logic [127:0] regs_flat;
    logic         wr_stb;
    logic [6:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         frame_err;
    logic         busy;

    spi_rxm_responder #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .spi       (bus.slave),
        .regs_flat (regs_flat),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_wr  = 0;
    int          n_err = 0;
    logic [6:0]  last_addr = '0;
    logic [7:0]  last_data = '0;
    logic [31:0] miso_bits;
    logic        mid_busy, mid_oe;
    logic [7:0]  exp_regs [16];

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            n_wr++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (frame_err === 1'b1) n_err++;
    end

    function automatic logic [127:0] exp_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = exp_regs[i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives nb bits of f MSB first; MISO is sampled just before each SCLK rise.
    task automatic spi_frame(input logic [31:0] f, input int nb, input int half, input bit raise);
        miso_bits = '0;
        @(negedge clk) bus.spi_ss_n = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = nb - 1; i >= 0; i--) begin
            bus.spi_mosi = f[i];
            repeat (half) @(negedge clk);
            miso_bits = {miso_bits[30:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            if (i == nb - 2) begin
                mid_busy = busy;
                mid_oe   = bus.spi_miso_oe;
            end
            repeat (half) @(negedge clk);
            bus.spi_sclk = 1'b0;
        end
        if (raise) begin
            repeat (half) @(negedge clk);
            bus.spi_ss_n = 1'b1;
            repeat (12) @(negedge clk);
        end
    endtask

    initial begin
        int halves [5];
        halves = '{4, 6, 8, 12, 16};
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        bus.spi_sclk = 1'b0;
        bus.spi_ss_n = 1'b1;
        bus.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_miso", 128'(bus.spi_miso), 128'(1'b0));
        chk("rst_oe", 128'(bus.spi_miso_oe), 128'(1'b0));
        chk("rst_regs", regs_flat, 128'h0);
        chk("rst_wr_stb", 128'(wr_stb), 128'(1'b0));
        chk("rst_wr_addr", 128'(wr_addr), 128'h0);
        chk("rst_wr_data", 128'(wr_data), 128'h0);
        chk("rst_frame_err", 128'(frame_err), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write 0x03A5 at 1:8
        spi_frame(32'h03A5, 16, 4, 1'b1);
        exp_regs[3] = 8'hA5;
        chk("wr1_count", 128'(n_wr), 128'(1));
        chk("wr1_addr", 128'(last_addr), 128'h3);
        chk("wr1_data", 128'(last_data), 128'hA5);
        chk("wr1_regs", regs_flat, exp_flat());
        chk("wr1_mid_busy", 128'(mid_busy), 128'(1'b1));
        chk("wr1_mid_oe", 128'(mid_oe), 128'(1'b1));
        chk("wr1_busy_after", 128'(busy), 128'(1'b0));
        chk("wr1_oe_after", 128'(bus.spi_miso_oe), 128'(1'b0));
        chk("wr1_no_err", 128'(n_err), 128'(0));

        // Read reg 3 at 1:16
        spi_frame(32'h8300, 16, 8, 1'b1);
        chk("rd3_data", 128'(miso_bits[7:0]), 128'hA5);
        chk("rd3_cmd_zero", 128'(miso_bits[15:8]), 128'h00);
        chk("rd3_no_wr", 128'(n_wr), 128'(1));

        // Out-of-range write and read at 1:12
        spi_frame(32'h20FF, 16, 6, 1'b1);
        chk("oor_wr_no_stb", 128'(n_wr), 128'(1));
        chk("oor_wr_regs", regs_flat, exp_flat());
        spi_frame(32'hA000, 16, 6, 1'b1);
        chk("oor_rd_data", 128'(miso_bits[15:0]), 128'h0000);

        // Abort after 10 bits of write 0x0577
        spi_frame(32'h0577 >> 6, 10, 4, 1'b1);
        chk("abort_err", 128'(n_err), 128'(1));
        chk("abort_no_wr", 128'(n_wr), 128'(1));
        chk("abort_regs", regs_flat, exp_flat());
        chk("abort_busy", 128'(busy), 128'(1'b0));

        // 20-bit frame: 0x0742 then four trailing ones
        spi_frame(32'h0742F, 20, 5, 1'b1);
        exp_regs[7] = 8'h42;
        chk("long_count", 128'(n_wr), 128'(2));
        chk("long_addr", 128'(last_addr), 128'h7);
        chk("long_data", 128'(last_data), 128'h42);
        chk("long_regs", regs_flat, exp_flat());
        chk("long_miso_tail", 128'(miso_bits[3:0]), 128'h0);
        chk("long_no_err", 128'(n_err), 128'(1));

        // Reset in the middle of a write (12 bits of 0x0233)
        spi_frame(32'h0233 >> 4, 12, 4, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        bus.spi_ss_n = 1'b1;
        bus.spi_sclk = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        chk("mrst_regs", regs_flat, 128'h0);
        chk("mrst_busy", 128'(busy), 128'(1'b0));
        chk("mrst_oe", 128'(bus.spi_miso_oe), 128'(1'b0));
        chk("mrst_miso", 128'(bus.spi_miso), 128'(1'b0));
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("mrst_no_wr", 128'(n_wr), 128'(2));

        // Fresh write 0x0111 at 1:32
        spi_frame(32'h0111, 16, 16, 1'b1);
        exp_regs[1] = 8'h11;
        chk("post_rst_count", 128'(n_wr), 128'(3));
        chk("post_rst_regs", regs_flat, exp_flat());

        // Ratio sweep: write reg 8+k = 0xC0|k, read it back
        for (int k = 0; k < 5; k++) begin
            logic [7:0] a, d;
            a = 8'(8 + k);
            d = 8'hC0 | 8'(k);
            spi_frame({16'h0, a, d}, 16, halves[k], 1'b1);
            exp_regs[8 + k] = d;
            chk("sweep_wr_regs", regs_flat, exp_flat());
            chk("sweep_wr_data", 128'(last_data), 128'(d));
            spi_frame({16'h0, a | 8'h80, 8'h00}, 16, halves[k], 1'b1);
            chk("sweep_rd_data", 128'(miso_bits[7:0]), 128'(d));
        end
        chk("sweep_total_wr", 128'(n_wr), 128'(8));
        chk("sweep_no_err", 128'(n_err), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
